arena_store: RTL and testbench
==============================

// Module: arena_store
// PURPOSE
//   Cell-state storage and responder for the arena row interface driven by the
//   solver. Holds ARENA_HEIGHT rows of ARENA_WIDTH cells and serves row reads and
//   writes on two ports: solver and host.
//   Also provides a sequenced clear engine and a valid/ready row-scan stream for
//   the display path. Sits between the solver, the host/loader and the display.
// PARAMETERS
//   ARENA_WIDTH   10  cells per row (bits per row word)
//   ARENA_HEIGHT  10  rows in arena, 1..256
// PORTS
//   clk                   in   1      clock
//   reset                 in   1      asynchronous, active-high
//   solver_ready          in   1      solver idle; 0 = solver owns write access
//   solver_row_select     in   8      row addressed by solver
//   solver_columns        out  W      row data at solver_row_select
//   solver_columns_new    in   W      row write data from solver
//   solver_columns_write  in   1      solver write strobe
//   host_row_select       in   8      row addressed by host
//   host_columns          out  W      row data at host_row_select
//   host_columns_new      in   W      row write data from host
//   host_columns_write    in   1      host write strobe
//   clear_req             in   1      start clear of whole arena
//   clear_busy            out  1      clear sequence in progress
//   scan_valid            out  1      scan_row/scan_columns valid
//   scan_ready            in   1      display consumes current scan word
//   scan_row              out  8      row index of scan word
//   scan_columns          out  W      captured row contents
//   scan_frame_start      out  1      scan word is row 0
// BEHAVIOUR
//   Reset (async, immediate):
//   - all rows = 0; clear_busy = 0; scan_valid = 0; scan_row = 0.
//   - scan_columns = 0; scan_frame_start = 0.
//   Reads:
//   - solver_columns, host_columns: combinational mem[row_select].
//   - Both read 0 when row_select >= ARENA_HEIGHT.
//   - Reads are always allowed on both ports regardless of ownership.
//   Ownership: owner = solver when solver_ready==0, else host. Sampled each
//   cycle, no latching.
//   Writes:
//   - Only the owner's strobe is honoured. At the posedge,
//     mem[row_select] <= columns_new.
//   - Non-owner strobe: ignored silently.
//   - row_select >= ARENA_HEIGHT: write ignored.
//   - A write is visible on read ports in the cycle after the edge.
//   Clear FSM, states IDLE / CLEAR:
//   - IDLE: clear_req=1 -> CLEAR, row counter k=0, clear_busy=1 from next cycle.
//   - CLEAR: each cycle mem[k] <= 0, k++.
//   - CLEAR: after k==ARENA_HEIGHT-1 is cleared -> IDLE.
//   - clear_busy is high for exactly ARENA_HEIGHT cycles.
//   - During CLEAR, all solver and host writes are ignored and clear_req is ignored.
//   - A write in the same cycle clear_req is accepted in IDLE is performed;
//     CLEAR then zeroes that row.
//   Scan stream (runs continuously, including during CLEAR):
//   - First cycle after reset release: load row 0, scan_valid=1.
//   - Transfer = scan_valid && scan_ready. On a transfer at an edge,
//     scan_row <= (scan_row==ARENA_HEIGHT-1) ? 0 : scan_row+1.
//   - On that same edge, scan_columns <= mem[next row] using pre-edge contents;
//     a write to that row on the same edge is not reflected.
//   - No transfer: scan_row and scan_columns hold stable; the word is not
//     refreshed by later writes.
//   - scan_valid stays 1 after the first load.
//   - scan_frame_start = (scan_row==0) whenever scan_valid.
//   Reset asserted mid-clear or mid-scan aborts immediately to reset values.
// TESTING
//   - Reset, then host writes rows 0..9 with i+1 -> host_columns and
//     solver_columns read i+1 per row; row_select=10 reads 0.
//   - solver_ready=0, host writes row 3=0x155 -> ignored.
//   - solver_ready=0, solver writes row 3=0x2AA -> reads 0x2AA next cycle.
//   - solver_ready=1, solver write to row 4 -> ignored; host write to row 4 -> applied.
//   - Fill arena with 0x3FF, pulse clear_req:
//     - clear_busy high exactly 10 cycles; all rows read 0 afterwards.
//     - Writes and a second clear_req issued mid-clear have no effect.
//   - scan_ready=1 constantly -> scan_row sequence 0,1,..,9,0,1;
//     scan_frame_start high only on row 0; scan_columns match mem.
//   - scan_ready=0 for 5 cycles while writing the displayed row -> scan_row and
//     scan_columns stay stable; on resume, advance by exactly one row.
//   - Assert reset during CLEAR at k=5 -> clear_busy=0, scan_valid=0, all rows 0
//     immediately; scan restarts at row 0 after release.

Source files
------------

// File: rtl/arena_store.sv
// Arena cell storage: two row ports with solver/host ownership,
// a sequenced whole-arena clear, and a valid/ready row-scan stream.
module arena_store #(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   solver_ready,
  input  logic [7:0]             solver_row_select,
  output logic [ARENA_WIDTH-1:0] solver_columns,
  input  logic [ARENA_WIDTH-1:0] solver_columns_new,
  input  logic                   solver_columns_write,
  input  logic [7:0]             host_row_select,
  output logic [ARENA_WIDTH-1:0] host_columns,
  input  logic [ARENA_WIDTH-1:0] host_columns_new,
  input  logic                   host_columns_write,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   scan_valid,
  input  logic                   scan_ready,
  output logic [7:0]             scan_row,
  output logic [ARENA_WIDTH-1:0] scan_columns,
  output logic                   scan_frame_start
);

  localparam int W = ARENA_WIDTH;
  localparam int H = ARENA_HEIGHT;
  localparam logic [7:0] LAST = 8'(H - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [W-1:0] mem [H];
  state_t       state, state_nx;
  logic [7:0]   k, k_nx;

  logic         wr_en;
  logic [7:0]   wr_row;
  logic [W-1:0] wr_data;
  logic [7:0]   scan_nx_row;
  logic [W-1:0] scan_nx_cols;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    clear_busy = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
          k_nx     = '0;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        k_nx       = k + 8'd1;
        if (k == LAST) begin
          state_nx = IDLE;
          k_nx     = '0;
        end
      end
    endcase
  end

  // solver owns the write path whenever it is not idle
  always_comb begin
    if (solver_ready) begin
      wr_en   = host_columns_write;
      wr_row  = host_row_select;
      wr_data = host_columns_new;
    end else begin
      wr_en   = solver_columns_write;
      wr_row  = solver_row_select;
      wr_data = solver_columns_new;
    end
    wr_en = wr_en && (state == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < H; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < H; i++) begin
        if (state == CLEAR) begin
          if (k == 8'(i)) mem[i] <= '0;
        end else if (wr_en && wr_row == 8'(i)) begin
          mem[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    solver_columns = '0;
    host_columns   = '0;
    scan_nx_cols   = '0;
    scan_nx_row    = (scan_row == LAST) ? 8'd0 : scan_row + 8'd1;
    for (int i = 0; i < H; i++) begin
      if (solver_row_select == 8'(i)) solver_columns = mem[i];
      if (host_row_select == 8'(i))   host_columns   = mem[i];
      if (scan_nx_row == 8'(i))       scan_nx_cols   = mem[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_valid   <= 1'b0;
      scan_row     <= '0;
      scan_columns <= '0;
    end else if (!scan_valid) begin
      scan_valid   <= 1'b1;
      scan_row     <= '0;
      scan_columns <= mem[0];
    end else if (scan_ready) begin
      scan_row     <= scan_nx_row;
      scan_columns <= scan_nx_cols;
    end
  end

  assign scan_frame_start = scan_valid && (scan_row == 8'd0);

endmodule

// File: tb/tb_arena_store.sv
// Self-checking bench for arena_store: directed scenarios plus
// randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_arena_store;

  localparam int W = 10;
  localparam int H = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         solver_ready = 1'b1;
  logic [7:0]   solver_row_select = '0;
  logic [W-1:0] solver_columns;
  logic [W-1:0] solver_columns_new = '0;
  logic         solver_columns_write = 1'b0;
  logic [7:0]   host_row_select = '0;
  logic [W-1:0] host_columns;
  logic [W-1:0] host_columns_new = '0;
  logic         host_columns_write = 1'b0;
  logic         clear_req = 1'b0;
  logic         clear_busy;
  logic         scan_valid;
  logic         scan_ready = 1'b0;
  logic [7:0]   scan_row;
  logic [W-1:0] scan_columns;
  logic         scan_frame_start;

  arena_store #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .solver_ready(solver_ready),
    .solver_row_select(solver_row_select),
    .solver_columns(solver_columns),
    .solver_columns_new(solver_columns_new),
    .solver_columns_write(solver_columns_write),
    .host_row_select(host_row_select),
    .host_columns(host_columns),
    .host_columns_new(host_columns_new),
    .host_columns_write(host_columns_write),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_row(scan_row), .scan_columns(scan_columns),
    .scan_frame_start(scan_frame_start)
  );

  always #5 clk = ~clk;

  // reference model: arena contents, clear cycles left, scan word
  logic [W-1:0] model [H];
  int           m_busy;
  bit           m_sv;
  int           m_row;
  logic [W-1:0] m_cols;
  int vectors = 0;
  int errors = 0;

  function automatic logic [W-1:0] mrd(input int r);
    return (r < H) ? model[r] : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < H; i++) model[i] = '0;
    m_busy = 0;
    m_sv = 0;
    m_row = 0;
    m_cols = '0;
  endtask

  task automatic tick();
    int nr;
    if (!reset) begin
      if (!m_sv) begin
        m_sv = 1; m_row = 0; m_cols = model[0];
      end else if (scan_ready) begin
        nr = (m_row + 1) % H;
        m_row = nr; m_cols = model[nr];
      end
      if (m_busy > 0) begin
        model[H - m_busy] = '0;
        m_busy--;
      end else begin
        if (!solver_ready && solver_columns_write
            && int'(solver_row_select) < H)
          model[int'(solver_row_select)] = solver_columns_new;
        else if (solver_ready && host_columns_write
                 && int'(host_row_select) < H)
          model[int'(host_row_select)] = host_columns_new;
        if (clear_req) m_busy = H;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    solver_columns_write = 0;
    host_columns_write = 0;
    clear_req = 0;
  endtask

  task automatic fill(input logic [W-1:0] v, input bit rnd);
    solver_ready = 1;
    for (int i = 0; i < H; i++) begin
      host_row_select = 8'(i);
      host_columns_new = rnd ? W'($urandom) : v;
      host_columns_write = 1;
      tick();
    end
    quiet();
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1;
    #12;
    vectors++;
    if (clear_busy !== 0 || scan_valid !== 0 || scan_row !== 0
        || scan_columns !== 0 || scan_frame_start !== 0) begin
      errors++;
      $display("FAIL reset_state: busy=%b sv=%b row=%0d cols=%h fs=%b want all 0",
               clear_busy, scan_valid, scan_row, scan_columns, scan_frame_start);
    end
    vectors++;
    if (host_columns !== 0 || solver_columns !== 0) begin
      errors++;
      $display("FAIL reset_mem: host=%h solver=%h want 0",
               host_columns, solver_columns);
    end
    @(negedge clk);
    reset = 0;
    tick();
    vectors++;
    if (scan_valid !== 1 || scan_row !== 0 || scan_frame_start !== 1) begin
      errors++;
      $display("FAIL scan_first_load: sv=%b row=%0d fs=%b want 1 0 1",
               scan_valid, scan_row, scan_frame_start);
    end
  endtask

  task automatic test_host_writes();
    solver_ready = 1;
    for (int i = 0; i < H; i++) begin
      host_row_select = 8'(i);
      host_columns_new = W'(i + 1);
      host_columns_write = 1;
      tick();
    end
    quiet();
    for (int i = 0; i <= H; i++) begin
      host_row_select = 8'(i);
      solver_row_select = 8'(i);
      tick();
      vectors++;
      if (host_columns !== ((i < H) ? W'(i + 1) : '0)
          || solver_columns !== host_columns) begin
        errors++;
        $display("FAIL row_read[%0d]: host=%h solver=%h want %h",
                 i, host_columns, solver_columns,
                 (i < H) ? W'(i + 1) : W'(0));
      end
    end
  endtask

  task automatic test_ownership();
    solver_ready = 0;
    host_row_select = 3;
    solver_row_select = 3;
    host_columns_new = 10'h155;
    host_columns_write = 1;
    tick();
    quiet();
    vectors++;
    if (host_columns !== 10'h004) begin
      errors++;
      $display("FAIL host_nonowner: row3=%h want 004", host_columns);
    end
    solver_columns_new = 10'h2AA;
    solver_columns_write = 1;
    tick();
    quiet();
    vectors++;
    if (solver_columns !== 10'h2AA || host_columns !== 10'h2AA) begin
      errors++;
      $display("FAIL solver_owner: row3=%h/%h want 2aa",
               solver_columns, host_columns);
    end
    solver_ready = 1;
    solver_row_select = 4;
    host_row_select = 4;
    solver_columns_new = 10'h111;
    solver_columns_write = 1;
    tick();
    quiet();
    vectors++;
    if (host_columns !== 10'h005) begin
      errors++;
      $display("FAIL solver_nonowner: row4=%h want 005", host_columns);
    end
    host_columns_new = 10'h222;
    host_columns_write = 1;
    tick();
    quiet();
    vectors++;
    if (solver_columns !== 10'h222) begin
      errors++;
      $display("FAIL host_owner: row4=%h want 222", solver_columns);
    end
  endtask

  task automatic test_clear();
    int c;
    fill(10'h3FF, 0);
    host_row_select = 2;
    host_columns_new = 10'h0AA;
    host_columns_write = 1;
    clear_req = 1;
    tick();
    quiet();
    c = 0;
    while (clear_busy === 1 && c < 30) begin
      c++;
      quiet();
      solver_ready = 1;
      if (c == 3) begin
        host_row_select = 7;
        host_columns_new = 10'h123;
        host_columns_write = 1;
        clear_req = 1;
      end
      if (c == 5) begin
        solver_ready = 0;
        solver_row_select = 8;
        solver_columns_new = 10'h321;
        solver_columns_write = 1;
      end
      tick();
    end
    quiet();
    solver_ready = 1;
    vectors++;
    if (c != H) begin
      errors++;
      $display("FAIL clear_busy_len: %0d cycles want %0d", c, H);
    end
    for (int i = 0; i < H; i++) begin
      host_row_select = 8'(i);
      tick();
      vectors++;
      if (host_columns !== '0 || host_columns !== mrd(i)
          || clear_busy !== 0) begin
        errors++;
        $display("FAIL clear_row[%0d]: got %h busy=%b want 0 busy=0",
                 i, host_columns, clear_busy);
      end
    end
  endtask

  task automatic test_scan();
    int n;
    scan_ready = 1;
    fill('0, 1);
    n = 0;
    while (scan_row !== 0 && n < 2 * H) begin
      n++;
      tick();
    end
    vectors++;
    if (scan_row !== 0) begin
      errors++;
      $display("FAIL scan_wrap_timeout: row=%0d want 0", scan_row);
    end
    for (int i = 0; i < H + 2; i++) begin
      vectors++;
      if (scan_row !== 8'(i % H) || scan_frame_start !== (i % H == 0)
          || scan_columns !== model[i % H] || scan_valid !== 1) begin
        errors++;
        $display("FAIL scan_seq[%0d]: row=%0d fs=%b cols=%h want %0d %b %h",
                 i, scan_row, scan_frame_start, scan_columns,
                 i % H, i % H == 0, model[i % H]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int r;
    logic [W-1:0] held;
    scan_ready = 0;
    tick();
    r = m_row;
    held = m_cols;
    solver_ready = 1;
    for (int i = 0; i < 5; i++) begin
      host_row_select = 8'(r);
      host_columns_new = held ^ W'(i + 1);
      host_columns_write = 1;
      tick();
      vectors++;
      if (scan_row !== 8'(r) || scan_columns !== held) begin
        errors++;
        $display("FAIL scan_hold[%0d]: row=%0d cols=%h want %0d %h",
                 i, scan_row, scan_columns, r, held);
      end
    end
    quiet();
    scan_ready = 1;
    tick();
    vectors++;
    if (scan_row !== 8'((r + 1) % H)
        || scan_columns !== model[(r + 1) % H]) begin
      errors++;
      $display("FAIL scan_resume: row=%0d cols=%h want %0d %h",
               scan_row, scan_columns, (r + 1) % H, model[(r + 1) % H]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      solver_ready = 1'($urandom);
      solver_row_select = 8'($urandom_range(0, H + 2));
      host_row_select = 8'($urandom_range(0, H + 2));
      solver_columns_new = W'($urandom);
      host_columns_new = W'($urandom);
      solver_columns_write = 1'($urandom);
      host_columns_write = 1'($urandom);
      clear_req = ($urandom_range(0, 39) == 0);
      scan_ready = 1'($urandom);
      tick();
      vectors++;
      if (host_columns !== mrd(int'(host_row_select))
          || solver_columns !== mrd(int'(solver_row_select))
          || clear_busy !== (m_busy > 0)
          || scan_valid !== m_sv || scan_row !== 8'(m_row)
          || scan_columns !== m_cols
          || scan_frame_start !== (m_sv && m_row == 0)) begin
        errors++;
        $display("FAIL random[%0d]: h=%h s=%h b=%b row=%0d cols=%h want %h %h %b %0d %h",
                 n, host_columns, solver_columns, clear_busy, scan_row,
                 scan_columns, mrd(int'(host_row_select)),
                 mrd(int'(solver_row_select)), m_busy > 0, m_row, m_cols);
      end
    end
    quiet();
    solver_ready = 1;
    while (m_busy > 0) tick();
  endtask

  task automatic test_reset_mid_clear();
    fill('0, 1);
    clear_req = 1;
    tick();
    quiet();
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (clear_busy !== 1) begin
      errors++;
      $display("FAIL mid_clear_busy: busy=%b want 1", clear_busy);
    end
    #2;
    reset = 1;
    #1;
    vectors++;
    if (clear_busy !== 0 || scan_valid !== 0 || scan_row !== 0
        || scan_columns !== 0 || scan_frame_start !== 0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b sv=%b row=%0d cols=%h want 0",
               clear_busy, scan_valid, scan_row, scan_columns);
    end
    model_reset();
    for (int i = 0; i < H; i++) begin
      host_row_select = 8'(i);
      tick();
      vectors++;
      if (host_columns !== '0) begin
        errors++;
        $display("FAIL abort_row[%0d]: got %h want 0", i, host_columns);
      end
    end
    @(negedge clk);
    reset = 0;
    tick();
    vectors++;
    if (scan_valid !== 1 || scan_row !== 0 || scan_columns !== '0
        || clear_busy !== 0) begin
      errors++;
      $display("FAIL scan_restart: sv=%b row=%0d cols=%h want 1 0 0",
               scan_valid, scan_row, scan_columns);
    end
  endtask

  initial begin
    test_reset();
    test_host_writes();
    test_ownership();
    test_clear();
    test_scan();
    test_stall();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
